// File: rtl/bcd_countdown.sv
// bcd_countdown: multi-digit BCD down-counter with load/run control.
// A three-state FSM (IDLE/RUN/DONE) gates counting; the borrow ripples
// through every digit within one clock, and each digit is updated with
// 4-bit logic only (no binary arithmetic on the whole word).
// Optional feature macro: BCD_COUNTDOWN_AUTORELOAD_EN. When defined, the last
// loaded (clamped) value is kept and reloaded on the first i_en tick after
// the count reaches zero, so the block keeps cycling in RUN.
module bcd_countdown #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                i_rst_n,
    input  logic                i_sclr,
    input  logic                i_load,
    input  logic [4*DIGITS-1:0] i_load_val,
    input  logic                i_en,
    input  logic                i_pause,
    output logic [4*DIGITS-1:0] o_cnt,
    output logic                o_zero,
    output logic                o_running,
    output logic                o_done
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_reg;
    state_t         state_next;
    logic [W-1:0]   cnt_reg;
    logic [W-1:0]   cnt_next;
    logic           done_reg;
    logic           done_next;
    logic           running_reg;
    logic           running_next;

    // Per-digit helpers: clamped load value, decremented value, borrow chain.
    logic [W-1:0]      load_clamped;
    logic [W-1:0]      cnt_dec;
    logic [DIGITS-1:0] borrow;
    logic              dec_to_zero;
    logic              cnt_is_zero;

`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
    logic [W-1:0]   reload_reg;
    logic [W-1:0]   reload_next;
`endif

    // Digit 0 always receives the borrow; a zero digit turns into 9 and
    // forwards the borrow to the next digit up.
    assign borrow[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            // Any digit code above 9 is stored as 9.
            assign load_clamped[gi*4 +: 4] =
                (i_load_val[gi*4 +: 4] > 4'd9) ? 4'd9 : i_load_val[gi*4 +: 4];

            // 4-bit digit decrement with borrow-in.
            assign cnt_dec[gi*4 +: 4] =
                !borrow[gi]                  ? cnt_reg[gi*4 +: 4] :
                (cnt_reg[gi*4 +: 4] == 4'd0) ? 4'd9 :
                                               cnt_reg[gi*4 +: 4] - 4'd1;

            if (gi < DIGITS - 1) begin : g_borrow
                assign borrow[gi+1] = borrow[gi] & (cnt_reg[gi*4 +: 4] == 4'd0);
            end
        end
    endgenerate

    // A zero count would decrement to all nines, so an all-zero result can
    // only come from a count of exactly one.
    assign dec_to_zero = (cnt_dec == '0);
    assign cnt_is_zero = (cnt_reg == '0);

    // Next-state, next-count and done-pulse logic; sclr > load > decrement.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        done_next  = 1'b0;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
        reload_next = reload_reg;
`endif
        if (i_sclr) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
            reload_next = '0;
`endif
        end else if (i_load) begin
            cnt_next = load_clamped;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
            reload_next = load_clamped;
`endif
            if (load_clamped == '0) begin
                // Loading zero counts as reaching zero: straight to DONE.
                state_next = ST_DONE;
                done_next  = 1'b1;
            end else begin
                state_next = ST_RUN;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_IDLE;
                end
                ST_RUN: begin
                    if (i_en && !i_pause && !cnt_is_zero) begin
                        cnt_next = cnt_dec;
                        if (dec_to_zero) begin
                            state_next = ST_DONE;
                            done_next  = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
                    // A zero reload value disables reloading entirely.
                    if (reload_reg != '0) begin
                        if (i_en) begin
                            cnt_next   = reload_reg;
                            state_next = ST_RUN;
                        end
                    end else begin
                        state_next = ST_IDLE;
                    end
`else
                    state_next = ST_IDLE;
`endif
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
        running_next = (state_next == ST_RUN);
    end

    // State, count and registered status flags.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            done_reg    <= 1'b0;
            running_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            done_reg    <= done_next;
            running_reg <= running_next;
        end
    end

`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
    // Reload register holding the last clamped load value.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            reload_reg <= '0;
        end else begin
            reload_reg <= reload_next;
        end
    end
`endif

    assign o_cnt     = cnt_reg;
    assign o_zero    = cnt_is_zero;
    assign o_running = running_reg;
    assign o_done    = done_reg;

endmodule

// File: tb/tb_bcd_countdown.sv
// tb_bcd_countdown: directed and randomized checks of bcd_countdown against a
// decimal-integer reference model (the count is held as a plain int).
module tb_bcd_countdown;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic         clk;
    logic         i_rst_n;
    logic         i_sclr;
    logic         i_load;
    logic [W-1:0] i_load_val;
    logic         i_en;
    logic         i_pause;
    logic [W-1:0] o_cnt;
    logic         o_zero;
    logic         o_running;
    logic         o_done;

    int total;
    int bad;

    // Reference model state.
    int m_val;
    int m_st;
    bit m_done;
    int m_reload;

    bcd_countdown #(.DIGITS(DIGITS)) dut (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_sclr     (i_sclr),
        .i_load     (i_load),
        .i_load_val (i_load_val),
        .i_en       (i_en),
        .i_pause    (i_pause),
        .o_cnt      (o_cnt),
        .o_zero     (o_zero),
        .o_running  (o_running),
        .o_done     (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // BCD word to decimal integer, treating digit codes above 9 as 9.
    function automatic int bcd_to_int(input logic [W-1:0] b);
        int v;
        int d;
        v = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = int'(b[i*4 +: 4]);
            if (d > 9) d = 9;
            v = v * 10 + d;
        end
        return v;
    endfunction

    function automatic logic [W-1:0] int_to_bcd(input int v);
        logic [W-1:0] b;
        int           t;
        b = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            b[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return b;
    endfunction

    task automatic model_reset();
        m_val    = 0;
        m_st     = M_IDLE;
        m_done   = 1'b0;
        m_reload = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int c;
        m_done = 1'b0;
        if (i_sclr) begin
            m_val    = 0;
            m_st     = M_IDLE;
            m_reload = 0;
        end else if (i_load) begin
            c        = bcd_to_int(i_load_val);
            m_val    = c;
            m_reload = c;
            if (c == 0) begin
                m_st   = M_DONE;
                m_done = 1'b1;
            end else begin
                m_st = M_RUN;
            end
        end else if (m_st == M_RUN) begin
            if (i_en && !i_pause && m_val > 0) begin
                m_val = m_val - 1;
                if (m_val == 0) begin
                    m_st   = M_DONE;
                    m_done = 1'b1;
                end
            end
        end else if (m_st == M_DONE) begin
            if (AUTO && m_reload != 0) begin
                if (i_en) begin
                    m_val = m_reload;
                    m_st  = M_RUN;
                end
            end else begin
                m_st = M_IDLE;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".cnt"}, 32'(o_cnt), 32'(int_to_bcd(m_val)));
        chk({tag, ".zero"}, 32'(o_zero), 32'(m_val == 0));
        chk({tag, ".run"}, 32'(o_running), 32'(m_st == M_RUN));
        chk({tag, ".done"}, 32'(o_done), 32'(m_done));
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    task automatic set_in(input bit sclr, input bit load, input logic [W-1:0] val,
                          input bit en, input bit pause);
        i_sclr     = sclr;
        i_load     = load;
        i_load_val = val;
        i_en       = en;
        i_pause    = pause;
        if (sclr || load)
            $display("txn t=%0t sclr=%0b load=%0b val=%h en=%0b pause=%0b",
                     $time, sclr, load, val, en, pause);
    endtask

    int done_cnt;
    int r;
    logic [W-1:0] v;
    logic [W-1:0] auto_seq [6];

    initial begin
        total = 0;
        bad   = 0;
        model_reset();
        i_rst_n = 1'b0;
        set_in(0, 0, '0, 0, 0);
        #12;
        chk("rst.cnt", 32'(o_cnt), 32'h0);
        chk("rst.zero", 32'(o_zero), 32'h1);
        chk("rst.run", 32'(o_running), 32'h0);
        chk("rst.done", 32'(o_done), 32'h0);
        i_rst_n = 1'b1;

        // Asynchronous reset in the middle of a count.
        set_in(0, 1, 16'h0042, 0, 0);
        step("mid.load");
        set_in(0, 0, '0, 1, 0);
        step("mid.tick");
        chk("mid.val", 32'(o_cnt), 32'h0041);
        #2 i_rst_n = 1'b0;
        #1;
        model_reset();
        $display("txn t=%0t async reset asserted", $time);
        chk("arst.cnt", 32'(o_cnt), 32'h0);
        chk("arst.run", 32'(o_running), 32'h0);
        chk("arst.zero", 32'(o_zero), 32'h1);
        #2 i_rst_n = 1'b1;

        // 0x0100 with i_en held: load wins over the tick, then 99, 98, ...
        set_in(0, 1, 16'h0100, 1, 0);
        step("c100.load");
        chk("c100.first", 32'(o_cnt), 32'h0100);
        set_in(0, 0, '0, 1, 0);
        step("c100.t1");
        chk("c100.99", 32'(o_cnt), 32'h0099);
        step("c100.t2");
        chk("c100.98", 32'(o_cnt), 32'h0098);
        for (int i = 0; i < 98; i++) step("c100.run");
        chk("c100.zero", 32'(o_cnt), 32'h0);
        chk("c100.done", 32'(o_done), 32'h1);
        i_en = 1'b0;
        step("c100.after");
        chk("c100.done_off", 32'(o_done), 32'h0);
        chk("c100.stopped", 32'(o_running), 32'h0);

        // Full borrow ripple.
        set_in(0, 1, 16'h1000, 0, 0);
        step("ripple.load");
        set_in(0, 0, '0, 1, 0);
        step("ripple.tick");
        chk("ripple.0999", 32'(o_cnt), 32'h0999);

        // 0x0003 with toggling i_en and a 5-cycle pause window.
        set_in(0, 1, 16'h0003, 0, 0);
        step("pause.load");
        done_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            set_in(0, 0, '0, (i % 2) == 1, (i >= 2 && i < 7));
            step("pause.run");
            if (o_done) done_cnt++;
        end
        chk("pause.done_once", 32'(done_cnt), 32'h1);
        set_in(0, 0, '0, 0, 0);
        step("pause.idle");
        chk("pause.nowrap", 32'(o_cnt), 32'h0);

        // Clamping, load+en priority, sclr+load priority.
        set_in(0, 1, 16'hF0A5, 0, 0);
        step("clamp.load");
        chk("clamp.9095", 32'(o_cnt), 32'h9095);
        set_in(0, 1, 16'h0057, 1, 0);
        step("ld_en");
        chk("ld_en.val", 32'(o_cnt), 32'h0057);
        set_in(1, 1, 16'h0033, 1, 0);
        step("clr_ld");
        chk("clr_ld.cnt", 32'(o_cnt), 32'h0);
        chk("clr_ld.run", 32'(o_running), 32'h0);
        chk("clr_ld.done", 32'(o_done), 32'h0);

        // Loading zero: single done pulse, count stays zero.
        set_in(0, 1, 16'h0000, 0, 0);
        step("ld0");
        chk("ld0.done", 32'(o_done), 32'h1);
        set_in(0, 0, '0, 1, 0);
        step("ld0.next");
        chk("ld0.done_off", 32'(o_done), 32'h0);
        chk("ld0.cnt", 32'(o_cnt), 32'h0);
        chk("ld0.run", 32'(o_running), 32'h0);

        // Load 2 with continuous i_en: with reload 2,1,0,2,1,0; without 2,1,0,0,0,0.
        auto_seq[0] = 16'h0002;
        auto_seq[1] = 16'h0001;
        auto_seq[2] = 16'h0000;
        auto_seq[3] = AUTO ? 16'h0002 : 16'h0000;
        auto_seq[4] = AUTO ? 16'h0001 : 16'h0000;
        auto_seq[5] = 16'h0000;
        set_in(0, 1, 16'h0002, 1, 0);
        step("auto.load");
        set_in(0, 0, '0, 1, 0);
        chk("auto.s0", 32'(o_cnt), 32'(auto_seq[0]));
        for (int i = 1; i < 6; i++) begin
            step("auto.run");
            chk($sformatf("auto.s%0d", i), 32'(o_cnt), 32'(auto_seq[i]));
        end
        set_in(1, 0, '0, 0, 0);
        step("auto.clr");

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 99));
            case ($urandom_range(0, 3))
                0: v = W'($urandom);
                1: v = int_to_bcd(int'($urandom_range(0, 5)));
                2: v = '0;
                default: v = int_to_bcd(int'($urandom_range(0, 9999)));
            endcase
            set_in(r < 2, (r >= 2 && r < 8), v, $urandom_range(0, 9) < 7,
                   $urandom_range(0, 9) < 2);
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
